// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Front-end fetch sequencer. Issues instruction-memory reads at the current
// fetch PC and pushes each returned {instruction, pc} pair into the
// instruction queue. When the queue is full as a response arrives, the
// response is parked in a one-entry hold register. On a flush the PC is
// redirected, and any memory response still in flight is swallowed.
//
// Optional build macro: FETCH_PERF_EN
//   When defined, two saturating performance counters are added as ports.
//
// Parameters
//   XLEN       address / instruction width
//   RESET_PC   first fetch address after reset
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   flush        single-cycle redirect request from commit
//   flush_pc     redirect target, valid while flush is high
//   imem_addr    instruction-memory read address
//   imem_read    read request, held until imem_resp
//   imem_resp    single-cycle read-data-valid
//   imem_rdata   returned instruction word
//   iq_full      instruction queue cannot accept an entry
//   iq_enq       enqueue strobe to the instruction queue
//   iq_data      instruction being enqueued
//   iq_pc        PC of the instruction being enqueued
//   perf_fetched (FETCH_PERF_EN) count of enqueued instructions
//   perf_dropped (FETCH_PERF_EN) count of responses / held entries discarded
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h6000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [XLEN-1:0] flush_pc,
   output logic [XLEN-1:0] imem_addr,
   output logic            imem_read,
   input  logic            imem_resp,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            iq_full,
   output logic            iq_enq,
   output logic [XLEN-1:0] iq_data,
   output logic [XLEN-1:0] iq_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [XLEN-1:0] perf_fetched,
   output logic [XLEN-1:0] perf_dropped
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD,
      DISCARD
   } state_t;

   localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] hold_data;
   logic [XLEN-1:0] hold_pc;

   logic [XLEN-1:0] req_next;
   logic [XLEN-1:0] hold_next;
   logic            wait_enq;
   logic            hold_enq;

   // Sequential successors of the outstanding and the parked fetch. Plain
   // XLEN-bit addition, so the PC wraps from the top of memory back to 0.
   assign req_next  = req_addr + INSN_BYTES;
   assign hold_next = hold_pc + INSN_BYTES;

   // The memory request is live in WAIT and also in DISCARD: a request that
   // has been issued cannot be withdrawn, so it stays asserted at the same
   // address until its response arrives, even though the data will be dropped.
   assign imem_read = (state == WAIT) || (state == DISCARD);
   assign imem_addr = req_addr;

   // An entry reaches the queue either straight from a fresh response or
   // from the hold register. A flush in the same cycle always wins, so a
   // stale instruction never makes it into the queue.
   assign wait_enq = (state == WAIT) && imem_resp && !flush && !iq_full;
   assign hold_enq = (state == HOLD) && !flush && !iq_full;

   // Enqueue payload mux. The bus reads as zero whenever nothing is being
   // enqueued, which also gives clean zeros while reset is held.
   always_comb begin
      iq_enq  = wait_enq || hold_enq;
      iq_data = '0;
      iq_pc   = '0;
      if (wait_enq) begin
         iq_data = imem_rdata;
         iq_pc   = req_addr;
      end else if (hold_enq) begin
         iq_data = hold_data;
         iq_pc   = hold_pc;
      end
   end

   // Fetch sequencer. IDLE launches a request once the queue has room, WAIT
   // streams responses into the queue back to back, HOLD parks one response
   // while the queue is full, and DISCARD waits out a request that a flush
   // has made stale. Every flush updates pc, so the most recent redirect is
   // the one that gets fetched next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_addr  <= RESET_PC;
         hold_data <= '0;
         hold_pc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  pc <= flush_pc;
               end else if (!iq_full) begin
                  req_addr <= pc;
                  state    <= WAIT;
               end
            end

            WAIT: begin
               if (imem_resp) begin
                  if (flush) begin
                     pc    <= flush_pc;
                     state <= IDLE;
                  end else if (!iq_full) begin
                     pc       <= req_next;
                     req_addr <= req_next;
                  end else begin
                     hold_data <= imem_rdata;
                     hold_pc   <= req_addr;
                     state     <= HOLD;
                  end
               end else if (flush) begin
                  pc    <= flush_pc;
                  state <= DISCARD;
               end
            end

            HOLD: begin
               if (flush) begin
                  pc    <= flush_pc;
                  state <= IDLE;
               end else if (!iq_full) begin
                  pc       <= hold_next;
                  req_addr <= hold_next;
                  state    <= WAIT;
               end
            end

            DISCARD: begin
               if (flush) begin
                  pc <= flush_pc;
               end
               if (imem_resp) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic drop_event;

   // A drop is a response that arrives with or after a flush, or a parked
   // entry thrown away by a flush while the queue was full.
   assign drop_event = ((state == WAIT) && imem_resp && flush)
                    || ((state == DISCARD) && imem_resp)
                    || ((state == HOLD) && flush);

   // Performance counters. Both stick at all-ones instead of wrapping so a
   // long run never reports a deceptively small number.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         if (iq_enq && (perf_fetched != '1)) begin
            perf_fetched <= perf_fetched + XLEN'(1);
         end
         if (drop_event && (perf_dropped != '1)) begin
            perf_dropped <= perf_dropped + XLEN'(1);
         end
      end
   end
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Front-end fetch sequencer for the out-of-order core.
- Issues instruction-memory reads at the current fetch PC and pushes each returned {instruction, pc} into the instruction queue, which has 16 entries by default.
- Handles queue backpressure with a one-entry hold register.
- Handles branch/exception flush: the PC is redirected and any in-flight stale memory response is discarded.

Parameters:
- RESET_PC, 32'h6000_0000, first fetch address after reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  redirect request from commit; single-cycle pulse.
- flush_pc  input  XLEN  target PC, valid when flush=1.
- imem_addr  output  XLEN  read address; stable while imem_read=1.
- imem_read  output  1  read request; held high until imem_resp.
- imem_resp  input  1  read data valid; single cycle.
- imem_rdata  input  XLEN  returned instruction.
- iq_full  input  1  instruction queue full.
- iq_enq  output  1  enqueue strobe to the instruction queue.
- iq_data  output  XLEN  instruction to enqueue.
- iq_pc  output  XLEN  PC of the instruction to enqueue.

Behaviour:
- Registers:
  - pc: next PC to fetch.
  - req_addr: address of the outstanding request.
  - hold_data / hold_pc: one-entry hold buffer.
  - state: one of IDLE, WAIT, HOLD, DISCARD.
- Reset (async): state=IDLE, pc=RESET_PC, req_addr=RESET_PC, hold regs=0.
- Outputs during and after reset until the first transition: imem_read=0, iq_enq=0, iq_data=0, iq_pc=0.
- Outputs are combinational from state and inputs:
  - imem_read=1 iff state is WAIT or DISCARD.
  - imem_addr=req_addr.
- IDLE:
  - flush: pc<=flush_pc; stay in IDLE.
  - else if !iq_full: req_addr<=pc; go to WAIT.
  - else stay in IDLE.
- WAIT:
  - resp && flush: drop the data; pc<=flush_pc; go to IDLE; iq_enq=0.
  - resp && !flush && !iq_full: iq_enq=1, iq_data=imem_rdata, iq_pc=req_addr (same cycle). Then pc<=req_addr+4 and req_addr<=req_addr+4; stay in WAIT. This gives back-to-back fetch, one instruction per response.
  - resp && !flush && iq_full: hold_data<=imem_rdata, hold_pc<=req_addr; go to HOLD.
  - !resp && flush: pc<=flush_pc; go to DISCARD. Request stays asserted at the old req_addr, because memory cannot be cancelled.
- HOLD (imem_read=0):
  - flush: discard the hold buffer; pc<=flush_pc; go to IDLE.
  - else if !iq_full: iq_enq=1 with hold_data/hold_pc; pc<=hold_pc+4, req_addr<=hold_pc+4; go to WAIT.
  - else stay in HOLD.
- DISCARD:
  - flush: pc<=flush_pc (latest flush wins); stay unless resp is also high.
  - resp: drop the data, never enqueue it; go to IDLE.
- Boundary rules:
  - iq_enq is never asserted while iq_full=1 or flush=1.
  - iq_enq is never asserted in the same cycle as a dropped response.
  - PC addition wraps modulo 2^XLEN; 32'hFFFF_FFFC+4 gives 0.
  - imem_addr must not change while imem_read=1 and imem_resp=0.
  - rst mid-transaction returns to IDLE immediately. A later stray imem_resp in IDLE is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, the block adds two output ports, each XLEN bits wide, both reset to 0 and both saturating at all-ones:
  - perf_fetched: increments on each iq_enq.
  - perf_dropped: increments on each response dropped in WAIT (flush coincident with resp) or in DISCARD, and on each hold-buffer discard.
- When undefined: neither port nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset; memory responds one cycle after each request; iq_full=0.
  - Required: imem_addr sequence 6000_0000, 6000_0004, 6000_0008.
  - Required: iq_enq pulses with iq_pc equal to those values and iq_data equal to the memory contents.
- iq_full=1 when the response for 6000_0004 arrives; hold iq_full for 3 cycles.
  - Required: HOLD entered, imem_read=0, no iq_enq.
  - Required: after iq_full falls, one iq_enq with iq_pc=6000_0004, then a fetch at 6000_0008.
- flush with flush_pc=6000_0100 while the request at 6000_0008 is pending (no resp).
  - Required: imem_addr stays 6000_0008 until resp; that response is not enqueued.
  - Required: the next request is at 6000_0100.
- flush and imem_resp in the same WAIT cycle, flush_pc=6000_0200.
  - Required: no iq_enq; next request at 6000_0200.
- Two flushes in DISCARD (6000_0300, then 6000_0400) before resp.
  - Required: the next fetch is at 6000_0400.
  - Required with FETCH_PERF_EN: perf_dropped increments by exactly 1.
- Assert rst for one cycle while in WAIT.
  - Required: imem_read=0 and iq_enq=0 immediately.
  - Required: the fetch restarts at 6000_0000.
